// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, grant encoding and writeback request type for
// the register-file writeback arbiter and its scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_NUM    = 32;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: 2-bit outstanding-write counters for x1..x31, source busy
// lookup and a sticky overflow/underflow error flag. x0 is never tracked.
module wb_scoreboard
  import regfile_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  i_issue_en,
  input  logic [REG_ADDR_W-1:0] i_issue_addr,
  input  logic                  i_wb_en,
  input  logic [REG_ADDR_W-1:0] i_wb_addr,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  output logic                  o_sb_err
);

  logic [1:0]           r_cnt [REG_NUM];
  logic                 r_err;
  logic [REG_NUM-1:1]   w_inc;
  logic [REG_NUM-1:1]   w_dec;
  logic                 w_ovf;
  logic                 w_udf;

  // Decode per-register increment/decrement and detect saturation events.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    w_ovf = 1'b0;
    w_udf = 1'b0;
    for (int unsigned i = 1; i < REG_NUM; i++) begin
      w_inc[i] = i_issue_en && (i_issue_addr == REG_ADDR_W'(i));
      w_dec[i] = i_wb_en    && (i_wb_addr    == REG_ADDR_W'(i));
      if (w_inc[i] && !w_dec[i] && (r_cnt[i] == 2'd3)) w_ovf = 1'b1;
      if (w_dec[i] && !w_inc[i] && (r_cnt[i] == 2'd0)) w_udf = 1'b1;
    end
  end

  // Saturating counter update; a coincident increment and decrement cancel.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < REG_NUM; i++) r_cnt[i] <= '0;
      r_err <= 1'b0;
    end else begin
      for (int unsigned i = 1; i < REG_NUM; i++) begin
        if (w_inc[i] && !w_dec[i] && (r_cnt[i] != 2'd3))
          r_cnt[i] <= r_cnt[i] + 2'd1;
        else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != 2'd0))
          r_cnt[i] <= r_cnt[i] - 2'd1;
      end
      if (w_ovf || w_udf) r_err <= 1'b1;
    end
  end

  // Busy lookup; x0 always reads as not busy.
  always_comb begin
    o_rs1_busy = (i_rs1_addr != '0) && (r_cnt[i_rs1_addr] != 2'd0);
    o_rs2_busy = (i_rs2_addr != '0) && (r_cnt[i_rs2_addr] != 2'd0);
  end

  assign o_sb_err = r_err;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU and LSU writebacks onto a single
// register-file write port with one cycle of latency, and tracks
// outstanding writes through wb_scoreboard.
// Build option REGFILE_WB_RR_EN: round-robin on contention; otherwise the
// LSU has fixed priority. XLEN is expected to match regfile_pkg::XLEN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = regfile_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            alu_wb_valid_i,
  input  logic [4:0]      alu_wb_addr_i,
  input  logic [XLEN-1:0] alu_wb_data_i,
  output logic            alu_wb_ready_o,
  input  logic            lsu_wb_valid_i,
  input  logic [4:0]      lsu_wb_addr_i,
  input  logic [XLEN-1:0] lsu_wb_data_i,
  output logic            lsu_wb_ready_o,
  output logic            rd_wr_en_o,
  output logic [4:0]      rd_wr_addr_o,
  output logic [XLEN-1:0] rd_wr_data_o,
  input  logic            issue_en_i,
  input  logic [4:0]      issue_addr_i,
  input  logic [4:0]      rs1_rd_addr_i,
  input  logic [4:0]      rs2_rd_addr_i,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  output logic            sb_err_o
);

  logic    w_alu_gnt;
  logic    w_lsu_gnt;
  wb_req_t w_grant;
  wb_req_t r_wr;

`ifdef REGFILE_WB_RR_EN
  grant_e r_last;

  // Round-robin: on contention grant whichever side was not granted last.
  always_comb begin
    w_alu_gnt = 1'b0;
    w_lsu_gnt = 1'b0;
    if (rst_n_i) begin
      if (alu_wb_valid_i && lsu_wb_valid_i) begin
        if (r_last == GRANT_ALU) w_lsu_gnt = 1'b1;
        else                     w_alu_gnt = 1'b1;
      end else begin
        w_alu_gnt = alu_wb_valid_i;
        w_lsu_gnt = lsu_wb_valid_i;
      end
    end
  end

  // Remember the most recent grant, contended or not.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)       r_last <= GRANT_ALU;
    else if (w_lsu_gnt) r_last <= GRANT_LSU;
    else if (w_alu_gnt) r_last <= GRANT_ALU;
  end
`else
  // Fixed priority: LSU wins over ALU; nothing is granted during reset.
  always_comb begin
    w_lsu_gnt = rst_n_i && lsu_wb_valid_i;
    w_alu_gnt = rst_n_i && alu_wb_valid_i && !lsu_wb_valid_i;
  end
`endif

  assign alu_wb_ready_o = w_alu_gnt;
  assign lsu_wb_ready_o = w_lsu_gnt;

  // Select the granted request.
  always_comb begin
    w_grant = '0;
    if (w_lsu_gnt) begin
      w_grant.valid = 1'b1;
      w_grant.addr  = lsu_wb_addr_i;
      w_grant.data  = lsu_wb_data_i;
    end else if (w_alu_gnt) begin
      w_grant.valid = 1'b1;
      w_grant.addr  = alu_wb_addr_i;
      w_grant.data  = alu_wb_data_i;
    end
  end

  // Output register: one write pulse per grant, suppressed for x0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr <= '0;
    end else begin
      r_wr.valid <= w_grant.valid && (w_grant.addr != '0);
      if (w_grant.valid) begin
        r_wr.addr <= w_grant.addr;
        r_wr.data <= w_grant.data;
      end
    end
  end

  assign rd_wr_en_o   = r_wr.valid;
  assign rd_wr_addr_o = r_wr.addr;
  assign rd_wr_data_o = r_wr.data;

  wb_scoreboard u_sb (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .i_issue_en   (issue_en_i),
    .i_issue_addr (issue_addr_i),
    .i_wb_en      (rd_wr_en_o),
    .i_wb_addr    (rd_wr_addr_o),
    .i_rs1_addr   (rs1_rd_addr_i),
    .i_rs2_addr   (rs2_rd_addr_i),
    .o_rs1_busy   (rs1_busy_o),
    .o_rs2_busy   (rs2_busy_o),
    .o_sb_err     (sb_err_o)
  );

endmodule
